// File: rtl/hazard_forward_unit.sv
// Hazard detection and EX operand forwarding for a 5-stage pipeline.
// Load-use stalls last LOAD_LAT cycles; forwarding selects are registered into EX.
//
// state | meaning
// RUN   | cnt == 0, stall only on a fresh load-use hit
// STALL | cnt  > 0, remaining load-use stall cycles after the current one
module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NUM_SRC*AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic                   ex_bubble,
  output logic [2*NUM_SRC-1:0]   ex_fwd_sel,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [LW-1:0] LAT_M1 = LW'(LOAD_LAT - 1);

  logic          ex_v, ex_rw, ex_mr;
  logic          mem_v, mem_rw, mem_mr;
  logic          wb_v, wb_rw, wb_mr;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;

  logic [NUM_SRC-1:0]   m_ex, m_mem, m_wb;
  logic [2*NUM_SRC-1:0] sel_nxt;
  logic                 load_use_hit, ex_load;
  logic [LW-1:0]        cnt, cnt_nxt;

  // Producer matching, youngest stage wins the select.
  always_comb begin
    m_ex    = '0;
    m_mem   = '0;
    m_wb    = '0;
    sel_nxt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_valid && id_rs_used[k] && (id_rs[k*AW +: AW] != '0)) begin
        m_ex[k]  = ex_v  & ex_rw  & (ex_rd  == id_rs[k*AW +: AW]);
        m_mem[k] = mem_v & mem_rw & (mem_rd == id_rs[k*AW +: AW]);
        m_wb[k]  = wb_v  & wb_rw  & (wb_rd  == id_rs[k*AW +: AW]);
      end
      if (m_ex[k])       sel_nxt[2*k +: 2] = 2'd1;
      else if (m_mem[k]) sel_nxt[2*k +: 2] = 2'd2;
      else if (m_wb[k])  sel_nxt[2*k +: 2] = 2'd3;
      else               sel_nxt[2*k +: 2] = 2'd0;
    end
  end

  assign load_use_hit = (|m_ex) & ex_mr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (flush)            cnt_nxt = '0;
    else if (cnt == '0) begin
      if (load_use_hit)   cnt_nxt = LAT_M1;
    end
    else                  cnt_nxt = cnt - LW'(1);
  end

  // Mealy stall: flush kills the ID instruction, so it never stalls.
  always_comb begin
    stall   = ~flush & (load_use_hit | (cnt != '0));
    ex_load = ~(stall | flush | ~id_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v       <= 1'b0;
      ex_rw      <= 1'b0;
      ex_mr      <= 1'b0;
      ex_rd      <= '0;
      mem_v      <= 1'b0;
      mem_rw     <= 1'b0;
      mem_mr     <= 1'b0;
      mem_rd     <= '0;
      wb_v       <= 1'b0;
      wb_rw      <= 1'b0;
      wb_mr      <= 1'b0;
      wb_rd      <= '0;
      ex_bubble  <= 1'b1;
      ex_fwd_sel <= '0;
    end
    else begin
      wb_v       <= mem_v;
      wb_rw      <= mem_rw;
      wb_mr      <= mem_mr;
      wb_rd      <= mem_rd;
      mem_v      <= ex_v;
      mem_rw     <= ex_rw;
      mem_mr     <= ex_mr;
      mem_rd     <= ex_rd;
      ex_v       <= ex_load;
      ex_rw      <= ex_load & id_regwrite;
      ex_mr      <= ex_load & id_memread;
      ex_rd      <= id_rd;
      ex_bubble  <= ~ex_load;
      ex_fwd_sel <= ex_load ? sel_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboarded bench for hazard_forward_unit across three parameter sets
// sharing one ID stimulus stream.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_rs_used = '0;
  logic [4:0] id_rd = '0;

  logic s0, b0, s3, b3, sc, bc;
  logic [3:0] f0, f3, fc;
  logic [15:0] c0, c3;
  logic [1:0] cc;

  always #5 clk = ~clk;

  hazard_forward_unit u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(s0), .ex_bubble(b0), .ex_fwd_sel(f0), .stall_count(c0));

  hazard_forward_unit #(.LOAD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(s3), .ex_bubble(b3), .ex_fwd_sel(f3), .stall_count(c3));

  hazard_forward_unit #(.CNT_W(2)) uc (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(sc), .ex_bubble(bc), .ex_fwd_sel(fc), .stall_count(cc));

  int cur = 0;
  logic o_stall, o_bub;
  logic [3:0] o_sel;
  logic [15:0] o_cnt;

  always_comb begin
    o_stall = s0; o_bub = b0; o_sel = f0; o_cnt = c0;
    case (cur)
      1: begin o_stall = s3; o_bub = b3; o_sel = f3; o_cnt = c3; end
      2: begin o_stall = sc; o_bub = bc; o_sel = fc; o_cnt = {14'd0, cc}; end
      default: ;
    endcase
  end

  typedef struct {
    logic v; logic [4:0] rs0; logic [4:0] rs1; logic [1:0] used; logic [4:0] rd;
    logic rw; logic mr; logic fl; logic es; logic eb; logic [3:0] esel;
  } row_t;

  row_t sb[$];
  int n_pass = 0, n_total = 0;
  logic s_stall, s_bub;
  logic [3:0] s_sel;

  function automatic row_t r(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                             input logic [1:0] used, input logic [4:0] rd, input logic rw,
                             input logic mr, input logic fl, input logic es, input logic eb,
                             input logic [3:0] esel);
    row_t x;
    x.v = v; x.rs0 = rs0; x.rs1 = rs1; x.used = used; x.rd = rd; x.rw = rw;
    x.mr = mr; x.fl = fl; x.es = es; x.eb = eb; x.esel = esel;
    return x;
  endfunction

  function automatic row_t nop();
    return r(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'h0);
  endfunction

  // Drives one ID cycle, queues its expectation, samples stall before the edge
  // and the registered EX outputs after it.
  task automatic step(input row_t x);
    id_valid = x.v; id_rs = {x.rs1, x.rs0}; id_rs_used = x.used; id_rd = x.rd;
    id_regwrite = x.rw; id_memread = x.mr; flush = x.fl;
    sb.push_back(x);
    @(negedge clk);
    s_stall = o_stall;
    @(posedge clk);
    #1;
    s_bub = o_bub;
    s_sel = o_sel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_regwrite = 0; id_memread = 0; flush = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t e;
    @(negedge clk);
    reset = 1'b0;
    id_valid = 1; id_rs = {5'd9, 5'd9}; id_rs_used = 2'b11;
    #1;
    n_total += 5;
    if (s0 !== 1'b0) $display("FAIL reset_stall: got %b exp 0", s0); else n_pass++;
    if (b0 !== 1'b1) $display("FAIL reset_bubble: got %b exp 1", b0); else n_pass++;
    if (f0 !== 4'h0) $display("FAIL reset_sel: got %h exp 0", f0); else n_pass++;
    if (c0 !== 16'd0) $display("FAIL reset_count: got %0d exp 0", c0); else n_pass++;
    if (b3 !== 1'b1) $display("FAIL reset_bubble_l3: got %b exp 1", b3); else n_pass++;
    do_reset();
    e = nop();
    step(e);
    e = sb.pop_front();
    n_total += 2;
    if (s_stall !== e.es) $display("FAIL reset_idle_stall: got %b exp %b", s_stall, e.es); else n_pass++;
    if (s_bub !== e.eb) $display("FAIL reset_idle_bubble: got %b exp %b", s_bub, e.eb); else n_pass++;
  endtask

  task automatic test_back_to_back();
    row_t q[$];
    row_t e;
    cur = 0;
    do_reset();
    q.push_back(r(1, 0, 0, 2'b01, 9, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 9, 9, 2'b11, 10, 1, 0, 0, 0, 0, 4'b0101));
    q.push_back(nop());
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      n_total += 3;
      if (s_stall !== e.es) $display("FAIL b2b_stall[%0d]: got %b exp %b", i, s_stall, e.es); else n_pass++;
      if (s_bub !== e.eb) $display("FAIL b2b_bubble[%0d]: got %b exp %b", i, s_bub, e.eb); else n_pass++;
      if (s_sel !== e.esel) $display("FAIL b2b_sel[%0d]: got %b exp %b", i, s_sel, e.esel); else n_pass++;
    end
  endtask

  task automatic test_distance();
    row_t q[$];
    row_t e;
    logic [3:0] exp_sel;
    cur = 0;
    for (int g = 1; g <= 3; g++) begin
      do_reset();
      q.delete();
      exp_sel = (g == 1) ? 4'b1000 : (g == 2) ? 4'b1100 : 4'b0000;
      q.push_back(r(1, 0, 0, 2'b01, 9, 1, 0, 0, 0, 0, 4'h0));
      for (int n = 0; n < g; n++) q.push_back(nop());
      q.push_back(r(1, 0, 9, 2'b11, 11, 1, 0, 0, 0, 0, exp_sel));
      foreach (q[i]) begin
        step(q[i]);
        e = sb.pop_front();
        n_total += 3;
        if (s_stall !== e.es) $display("FAIL dist%0d_stall[%0d]: got %b exp %b", g, i, s_stall, e.es); else n_pass++;
        if (s_bub !== e.eb) $display("FAIL dist%0d_bubble[%0d]: got %b exp %b", g, i, s_bub, e.eb); else n_pass++;
        if (s_sel !== e.esel) $display("FAIL dist%0d_sel[%0d]: got %b exp %b", g, i, s_sel, e.esel); else n_pass++;
      end
    end
  endtask

  task automatic test_load_use(input int which, input int lat);
    row_t q[$];
    row_t e;
    cur = which;
    do_reset();
    q.push_back(r(1, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 4'h0));
    for (int n = 0; n < lat; n++) q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 1, 1, 4'h0));
    q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 0, 0, (lat == 1) ? 4'b1010 : 4'b0000));
    q.push_back(nop());
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      n_total += 3;
      if (s_stall !== e.es) $display("FAIL lu%0d_stall[%0d]: got %b exp %b", lat, i, s_stall, e.es); else n_pass++;
      if (s_bub !== e.eb) $display("FAIL lu%0d_bubble[%0d]: got %b exp %b", lat, i, s_bub, e.eb); else n_pass++;
      if (s_sel !== e.esel) $display("FAIL lu%0d_sel[%0d]: got %b exp %b", lat, i, s_sel, e.esel); else n_pass++;
    end
    n_total++;
    if (o_cnt !== 16'(lat)) $display("FAIL lu%0d_count: got %0d exp %0d", lat, o_cnt, lat); else n_pass++;
  endtask

  task automatic test_reg0_unused();
    row_t q[$];
    row_t e;
    cur = 0;
    do_reset();
    q.push_back(r(1, 0, 0, 2'b01, 0, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 0, 0, 2'b11, 13, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 0, 0, 2'b01, 9, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 9, 9, 2'b00, 14, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 4'h0));
    q.push_back(r(1, 9, 9, 2'b00, 14, 1, 0, 0, 0, 0, 4'h0));
    q.push_back(r(1, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 4'h0));
    q.push_back(r(1, 0, 0, 2'b11, 15, 1, 0, 0, 0, 0, 4'h0));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      n_total += 3;
      if (s_stall !== e.es) $display("FAIL r0_stall[%0d]: got %b exp %b", i, s_stall, e.es); else n_pass++;
      if (s_bub !== e.eb) $display("FAIL r0_bubble[%0d]: got %b exp %b", i, s_bub, e.eb); else n_pass++;
      if (s_sel !== e.esel) $display("FAIL r0_sel[%0d]: got %b exp %b", i, s_sel, e.esel); else n_pass++;
    end
    n_total++;
    if (o_cnt !== 16'd0) $display("FAIL r0_count: got %0d exp 0", o_cnt); else n_pass++;
  endtask

  task automatic test_flush(input int which);
    row_t q[$];
    row_t e;
    cur = which;
    do_reset();
    q.push_back(r(1, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 4'h0));
    q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 1, 0, 1, 4'h0));
    q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 0, 0, 4'b1010));
    foreach (q[i]) begin
      step(q[i]);
      e = sb.pop_front();
      n_total += 3;
      if (s_stall !== e.es) $display("FAIL flush%0d_stall[%0d]: got %b exp %b", which, i, s_stall, e.es); else n_pass++;
      if (s_bub !== e.eb) $display("FAIL flush%0d_bubble[%0d]: got %b exp %b", which, i, s_bub, e.eb); else n_pass++;
      if (s_sel !== e.esel) $display("FAIL flush%0d_sel[%0d]: got %b exp %b", which, i, s_sel, e.esel); else n_pass++;
    end
    n_total++;
    if (o_cnt !== 16'd0) $display("FAIL flush%0d_count: got %0d exp 0", which, o_cnt); else n_pass++;
  endtask

  task automatic test_saturate();
    row_t q[$];
    row_t e;
    cur = 2;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      q.delete();
      q.push_back(r(1, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 4'h0));
      q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 1, 1, 4'h0));
      q.push_back(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 0, 0, 4'b1010));
      foreach (q[i]) begin
        step(q[i]);
        e = sb.pop_front();
        n_total += 2;
        if (s_stall !== e.es) $display("FAIL sat%0d_stall[%0d]: got %b exp %b", k, i, s_stall, e.es); else n_pass++;
        if (s_sel !== e.esel) $display("FAIL sat%0d_sel[%0d]: got %b exp %b", k, i, s_sel, e.esel); else n_pass++;
      end
      n_total++;
      if (o_cnt !== 16'((k > 3) ? 3 : k)) $display("FAIL sat%0d_count: got %0d exp %0d", k, o_cnt, (k > 3) ? 3 : k);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t e;
    cur = 1;
    do_reset();
    step(r(1, 0, 0, 2'b01, 9, 1, 1, 0, 0, 0, 4'h0));
    e = sb.pop_front();
    step(r(1, 9, 9, 2'b11, 12, 1, 0, 0, 1, 1, 4'h0));
    e = sb.pop_front();
    @(negedge clk);
    n_total += 2;
    if (s3 !== 1'b1) $display("FAIL mid_stall_before: got %b exp 1", s3); else n_pass++;
    if (c3 !== 16'd1) $display("FAIL mid_count_before: got %0d exp 1", c3); else n_pass++;
    reset = 1'b0;
    #1;
    n_total += 4;
    if (s3 !== 1'b0) $display("FAIL mid_stall_reset: got %b exp 0", s3); else n_pass++;
    if (b3 !== 1'b1) $display("FAIL mid_bubble_reset: got %b exp 1", b3); else n_pass++;
    if (f3 !== 4'h0) $display("FAIL mid_sel_reset: got %h exp 0", f3); else n_pass++;
    if (c3 !== 16'd0) $display("FAIL mid_count_reset: got %0d exp 0", c3); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if (s3 !== 1'b0) $display("FAIL mid_stall_after: got %b exp 0", s3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use(0, 1);
    test_load_use(1, 3);
    test_reg0_unused();
    test_flush(0);
    test_flush(1);
    test_saturate();
    test_reset_mid_stall();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
